wb_writer: RTL

Write-back side of the integer register file: the single block that drives the register file's write port (wr_en / rd_addr / data_in) in the pipelined RISC-V core. Merges the single-cycle ALU result stream and the variable-latency data-memory load stream onto the one write port, formats load data (LB/LH/LW/LBU/LHU), buffers ALU results that collide with load returns, and exports a busy mask so decode can stall on pending writes.

---
 rtl/wb_pkg.sv | 47 ++++
 rtl/wb_fifo.sv | 61 ++++++
 rtl/wb_writer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the register-file write-back block.
package wb_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned RW           = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {S_IDLE, S_WAIT} ld_state_e;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] data;
    logic                    err;
  } ld_fmt_t;

  // Extract and extend load data; misaligned halves/words fall back to the aligned lane.
  function automatic ld_fmt_t fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                       input logic [XLEN_DEFAULT-1:0] word);
    ld_fmt_t     r;
    logic [7:0]  b;
    logic [15:0] h;
    b      = word[{off, 3'b000} +: 8];
    h      = off[1] ? word[31:16] : word[15:0];
    r.err  = 1'b0;
    r.data = word;
    case (f3)
      F3_LB:  r.data = {{(XLEN_DEFAULT-8){b[7]}}, b};
      F3_LBU: r.data = {{(XLEN_DEFAULT-8){1'b0}}, b};
      F3_LH: begin
        r.data = {{(XLEN_DEFAULT-16){h[15]}}, h};
        r.err  = off[0];
      end
      F3_LHU: begin
        r.data = {{(XLEN_DEFAULT-16){1'b0}}, h};
        r.err  = off[0];
      end
      F3_LW:   r.err = (off != 2'b00);
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// ALU result buffer: in-order rd/data FIFO exposing per-entry valid and rd for hazard tracking.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = 32,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [RW-1:0]            push_rd,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [RW-1:0]            head_rd_c,
  output logic [DW-1:0]            head_data_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [DEPTH-1:0]         ent_valid_c,
  output logic [DEPTH-1:0][RW-1:0] ent_rd
);

  logic [DW-1:0] data_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ent_rd <= '0;
    end else begin
      if (push) begin
        ent_rd[wr_ptr]   <= push_rd;
        data_mem[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_rd_c   = ent_rd[rd_ptr];
  assign head_data_c = data_mem[rd_ptr];
  assign full_c      = (count == (AW+1)'(DEPTH));
  assign empty_c     = (count == '0);

  // An entry is live when its distance from the read pointer is below the fill level.
  always_comb begin
    ent_valid_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_valid_c[i] = ({1'b0, AW'(AW'(i) - rd_ptr)} < count);
    end
  end

endmodule

// File: rtl/wb_writer.sv
// Register-file write port arbiter: merges ALU results and formatted load returns.
module wb_writer
  import wb_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_issue_valid,
  output logic            ld_issue_ready,
  input  logic [4:0]      ld_issue_rd,
  input  logic [2:0]      ld_issue_funct3,
  input  logic [1:0]      ld_issue_off,
  input  logic            ld_rsp_valid,
  input  logic [XLEN-1:0] ld_rsp_data,
  output logic            rf_wr_en,
  output logic [4:0]      rf_rd_addr,
  output logic [XLEN-1:0] rf_data,
  output logic [31:0]     busy_mask,
  output logic            err
);

  ld_state_e state_q, state_d;
  logic      issue_fire, rsp_fire, rsp_stray;
  logic [4:0] cap_rd;
  logic [2:0] cap_f3;
  logic [1:0] cap_off;
  ld_fmt_t   fmt;

  logic                          fifo_push, fifo_pop, fifo_full_c, fifo_empty_c;
  logic                          alu_acc, slot_free, direct;
  logic [4:0]                    head_rd_c;
  logic [XLEN-1:0]               head_data_c;
  logic [FIFO_DEPTH-1:0]         ent_valid_c;
  logic [FIFO_DEPTH-1:0][RW-1:0] ent_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    ld_issue_ready = 1'b0;
    issue_fire     = 1'b0;
    rsp_fire       = 1'b0;
    rsp_stray      = 1'b0;
    case (state_q)
      S_IDLE: begin
        ld_issue_ready = 1'b1;
        issue_fire     = ld_issue_valid;
        rsp_stray      = ld_rsp_valid;
        if (ld_issue_valid) state_d = S_WAIT;
      end
      S_WAIT: begin
        rsp_fire = ld_rsp_valid;
        if (ld_rsp_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fmt = fmt_load(cap_f3, cap_off, ld_rsp_data);

  // A load return owns the port; otherwise the oldest buffered ALU result, else the new one.
  assign alu_ready = !fifo_full_c;
  assign alu_acc   = alu_valid && alu_ready && (alu_rd != 5'd0);
  assign slot_free = !rsp_fire;
  assign fifo_pop  = slot_free && !fifo_empty_c;
  assign direct    = slot_free && fifo_empty_c && alu_acc;
  assign fifo_push = alu_acc && !direct;

  wb_fifo #(.DEPTH(FIFO_DEPTH), .DW(XLEN)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_rd    (alu_rd),
    .push_data  (alu_data),
    .pop        (fifo_pop),
    .head_rd_c  (head_rd_c),
    .head_data_c(head_data_c),
    .full_c     (fifo_full_c),
    .empty_c    (fifo_empty_c),
    .ent_valid_c(ent_valid_c),
    .ent_rd     (ent_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_rd     <= '0;
      cap_f3     <= '0;
      cap_off    <= '0;
      rf_wr_en   <= 1'b0;
      rf_rd_addr <= '0;
      rf_data    <= '0;
      err        <= 1'b0;
    end else begin
      if (issue_fire) begin
        cap_rd  <= ld_issue_rd;
        cap_f3  <= ld_issue_funct3;
        cap_off <= ld_issue_off;
      end
      rf_wr_en <= 1'b0;
      if (rsp_fire) begin
        rf_wr_en   <= (cap_rd != 5'd0);
        rf_rd_addr <= cap_rd;
        rf_data    <= XLEN'(fmt.data);
      end else if (fifo_pop) begin
        rf_wr_en   <= 1'b1;
        rf_rd_addr <= head_rd_c;
        rf_data    <= head_data_c;
      end else if (direct) begin
        rf_wr_en   <= 1'b1;
        rf_rd_addr <= alu_rd;
        rf_data    <= alu_data;
      end
      if (rsp_stray || (rsp_fire && fmt.err)) err <= 1'b1;
    end
  end

  // Pending writes: the outstanding load plus every buffered ALU result.
  always_comb begin
    busy_mask = '0;
    if (state_q == S_WAIT) busy_mask[cap_rd] = 1'b1;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_valid_c[i]) busy_mask[ent_rd[i]] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

endmodule
